frame_scan_controller: RTL and testbench
========================================

# frame_scan_controller

Sequences one full raster scan of the image ROM and delivers pixels, with their row/column coordinates, to the image masking module over a valid/ready handshake. It replaces free-running address generation with a start/abort-controlled scan, absorbs the ROM's one-cycle read latency, and tolerates backpressure through a two-entry skid buffer. It sits between the image ROM and the image masking module.

## Interface
Parameters:
- `IMAGE_WIDTH`, default 320: pixels per row; columns run 0..IMAGE_WIDTH-1.
- `IMAGE_HEIGHT`, default 240: rows per frame; rows run 0..IMAGE_HEIGHT-1.

Ports:
- `Clock`  in  1: single clock; all logic on the rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to scan a frame; honoured only in IDLE.
- `abort`  in  1: terminates the scan; takes priority over every other event.
- `rom_pixel`  in  12: ROM read data, valid one cycle after the address is driven.
- `rom_pix_row`  out  8: ROM row address, registered.
- `rom_pix_col`  out  9: ROM column address, registered.
- `pixel_out`  out  12: pixel sent to the image masking module.
- `pix_row`  out  8: row coordinate of `pixel_out`.
- `pix_col`  out  9: column coordinate of `pixel_out`.
- `pixel_valid`  out  1: `pixel_out`, `pix_row` and `pix_col` are valid.
- `pixel_ready`  in  1: consumer accepts the pixel when it is high together with `pixel_valid`.
- `busy`  out  1: high in SCAN and DRAIN.
- `frame_done`  out  1: one-cycle pulse when the last pixel is accepted.

## Operation
- States:
  - IDLE, then SCAN on `start`.
  - SCAN, then DRAIN after the last address issues.
  - DRAIN, then DONE when the last pixel is accepted.
  - DONE, then IDLE the following cycle.
  - `abort` in any state goes to IDLE.
- Issue rule: in SCAN, the controller drives the next address when (buffer occupancy + in-flight reads) < 2.
  - `issue` registers the address into `rom_pix_row`/`rom_pix_col`.
  - The coordinate travels with the read, and `rom_pixel` plus the coordinate are written into the buffer the next cycle.
- Address order: column increments first.
  - At `IMAGE_WIDTH-1` the column wraps to 0 and the row increments.
  - The last address is (`IMAGE_HEIGHT-1`, `IMAGE_WIDTH-1`).
  - Counters never exceed the range.
- Buffer: the output is the head entry. It pops on `pixel_valid && pixel_ready` and may be written and popped in the same cycle.
- `frame_done` is asserted in the DONE state, i.e. the cycle after the last accept.
- `abort`:
  - clears the buffer and in-flight flag and returns the counters to 0;
  - discards any pending read;
  - produces no `frame_done`;
  - a `start` in the same cycle as `abort` is ignored.
- `start` while busy is ignored.
- Reset values:
  - all address and coordinate outputs 0;
  - `pixel_out` 0;
  - `pixel_valid`, `busy`, `frame_done` 0;
  - state IDLE.

## Timing
- Cycle 0: `start` sampled high.
- Cycle 1: SCAN; address (0,0) on the ROM ports.
- Cycle 2: `rom_pixel` captured into the buffer.
- Cycle 3: `pixel_valid` high with (0,0). Start-to-first-pixel latency is 3 cycles.
- With `pixel_ready` held high, one pixel per cycle; a W×H frame completes in W·H+3 cycles, with `frame_done` in cycle W·H+3.
- `pixel_ready` low: `pixel_valid` and data stay stable, nothing is lost, and issue stalls within 1 cycle.
- `pixel_valid` never drops without an accept, except on `abort` or reset.

## Configuration
- `CONTINUOUS_SCAN_EN` defined: after the last address, SCAN continues at (0,0) of the next frame without returning to IDLE.
  - `frame_done` pulses at every last-pixel accept.
  - `busy` stays high.
  - Only `abort` stops the scan.
- `CONTINUOUS_SCAN_EN` undefined: single frame per `start`, as described above.

## Structure
- Shared package / `utils.v`:
  - `IMAGE_WIDTH`, `IMAGE_HEIGHT` defaults;
  - row/column width constants (8/9);
  - pixel width (12);
  - state encodings.
- Sub-module `pixel_skid_buffer`: two-entry FIFO of {row, col, pixel} with push, pop, flush and count outputs.

## Test plan
- Start, ready held high, W=4, H=3 → pixels (0,0)…(2,3) in raster order, 12 consecutive valid cycles starting cycle 3; `frame_done` pulses at cycle 15; `busy` falls after it.
- `pixel_ready` low for 5 cycles at pixel (1,2) → (1,2) held stable, ROM address frozen, no pixel lost or duplicated.
- `abort` at pixel (1,1) with buffer full → next cycle `pixel_valid`=0, `busy`=0, no `frame_done`; a new `start` restarts at (0,0).
- `start` pulsed during SCAN → ignored; exactly 12 pixels, one `frame_done`.
- `Reset_n` low mid-frame → all outputs 0 immediately, asynchronously, and state IDLE.
- `CONTINUOUS_SCAN_EN`, ready high → pixel 13 is (0,0); `frame_done` pulses every 12 accepts.

Source files
------------

// File: rtl/frame_scan_controller_pkg.sv
// Shared definitions for the frame scan controller.
// Holds the default image geometry, coordinate and pixel widths, the
// controller state encoding and the {row, col, pixel} entry that moves
// through the skid buffer.
// Build option: CONTINUOUS_SCAN_EN (see frame_scan_controller.sv).
package frame_scan_controller_pkg;

  localparam int IMAGE_WIDTH_DEF  = 320;
  localparam int IMAGE_HEIGHT_DEF = 240;

  localparam int ROW_W = 8;
  localparam int COL_W = 9;
  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] pixel;
  } pix_entry_t;

endpackage

// File: rtl/frame_scan_controller_pixel_skid_buffer.sv
// Two-entry FIFO of {row, col, pixel} between the ROM read and the consumer.
// The head entry is always presented on head_o; count_o tells how many
// entries are valid. Push and pop may happen in the same cycle (a push is
// accepted while full only when a pop frees a slot). flush_i empties the
// FIFO and takes priority over push/pop.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i into the tail
//   push_data_i     entry to write
//   pop_i           drop the head entry
//   flush_i         discard all entries
//   head_o          current head entry
//   count_o         number of valid entries (0..2)
module pixel_skid_buffer
  import frame_scan_controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  pix_entry_t push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output pix_entry_t head_o,
  output logic [1:0] count_o
);

  pix_entry_t mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/frame_scan_controller.sv
// Raster-scan sequencer between the image ROM and the image masking module.
// On start it walks every (row, col) address of the ROM in raster order
// (column first), absorbs the ROM's one-cycle read latency by carrying the
// coordinate alongside the read, and hands {pixel, row, col} to the consumer
// through a two-entry skid buffer with a valid/ready handshake.
// abort returns everything to IDLE immediately and discards pending data.
// Build option: CONTINUOUS_SCAN_EN - when defined the scan wraps to (0,0)
// after the last address and keeps running until abort; frame_done pulses
// after every last-pixel accept.
// Ports:
//   Clock, Reset_n            clock, asynchronous active-low reset
//   start, abort              scan request / scan termination
//   rom_pixel                 ROM read data (one cycle after address)
//   rom_pix_row, rom_pix_col  registered ROM address
//   pixel_out, pix_row, pix_col, pixel_valid, pixel_ready   output stream
//   busy                      high while scanning or draining
//   frame_done                one-cycle pulse after the last pixel is taken
module frame_scan_controller
  import frame_scan_controller_pkg::*;
#(
  parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PIX_W-1:0] rom_pixel,
  output logic [ROW_W-1:0] rom_pix_row,
  output logic [COL_W-1:0] rom_pix_col,
  output logic [PIX_W-1:0] pixel_out,
  output logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] pix_col,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             infl_q, infl_d;
  logic [ROW_W-1:0] infl_row_q, infl_row_d;
  logic [COL_W-1:0] infl_col_q, infl_col_d;

  pix_entry_t       head;
  pix_entry_t       push_data;
  logic [1:0]       buf_count;
  logic             pop, push, issue, room, last_addr, last_pop;
  logic [2:0]       occ_sum;

  assign pixel_valid = (buf_count != 2'd0);
  assign pop         = pixel_valid && pixel_ready;

  // Occupancy counted after this cycle's pop so a steady ready stream
  // still issues one address per cycle.
  assign occ_sum   = 3'(buf_count) - 3'(pop) + 3'(infl_q);
  assign room      = (occ_sum < 3'd2);
  assign last_addr = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign last_pop  = pop && (buf_count == 2'd1) && !infl_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    infl_d     = 1'b0;
    infl_row_d = infl_row_q;
    infl_col_d = infl_col_q;
    issue      = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_SCAN;
        ST_SCAN: begin
          issue = room;
          if (issue) begin
            infl_d     = 1'b1;
            infl_row_d = row_q;
            infl_col_d = col_q;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
`ifndef CONTINUOUS_SCAN_EN
            if (last_addr) state_d = ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: if (last_pop) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      infl_q     <= 1'b0;
      infl_row_q <= '0;
      infl_col_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      infl_q     <= infl_d;
      infl_row_q <= infl_row_d;
      infl_col_q <= infl_col_d;
    end
  end

  // ROM data arrives the cycle after issue; pair it with the carried coordinate.
  assign push      = infl_q && !abort;
  assign push_data = '{row: infl_row_q, col: infl_col_q, pixel: rom_pixel};

  pixel_skid_buffer u_skid (
    .clk_i       (Clock),
    .rst_ni      (Reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (abort),
    .head_o      (head),
    .count_o     (buf_count)
  );

  assign rom_pix_row = row_q;
  assign rom_pix_col = col_q;
  assign pixel_out   = head.pixel;
  assign pix_row     = head.row;
  assign pix_col     = head.col;
  assign busy        = (state_q == ST_SCAN) || (state_q == ST_DRAIN);

`ifdef CONTINUOUS_SCAN_EN
  logic done_q, done_d;

  assign done_d = pop && !abort && (head.row == ROW_LAST) && (head.col == COL_LAST);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) done_q <= 1'b0;
    else          done_q <= done_d;
  end

  assign frame_done = done_q;
`else
  assign frame_done = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_frame_scan_controller.sv
module tb_frame_scan_controller;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        start, abort, pixel_ready;
  logic [11:0] rom_pixel;
  logic [7:0]  rom_pix_row, pix_row;
  logic [8:0]  rom_pix_col, pix_col;
  logic [11:0] pixel_out;
  logic        pixel_valid, busy, frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: index of the next pixel the consumer should receive,
  // whether the controller should report busy, whether a frame_done pulse
  // is due, and whether the last shown pixel was left unaccepted.
  int exp_idx     = 0;
  bit m_busy      = 0;
  bit m_done_next = 0;
  bit m_done_cur  = 0;
  bit m_hold      = 0;

  frame_scan_controller #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .start       (start),
    .abort       (abort),
    .rom_pixel   (rom_pixel),
    .rom_pix_row (rom_pix_row),
    .rom_pix_col (rom_pix_col),
    .pixel_out   (pixel_out),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 Clock = ~Clock;

  function automatic logic [11:0] rom_f(input int r, input int c);
    return 12'((r * 37 + c * 11 + 5) ^ (r << 7));
  endfunction

  // Behavioural ROM with one cycle of read latency.
  always @(posedge Clock) rom_pixel <= rom_f(int'(rom_pix_row), int'(rom_pix_col));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Wait for the falling edge and check the cycle's outputs against the model.
  task automatic observe();
    @(negedge Clock);
    cyc++;
    m_done_cur  = m_done_next;
    m_done_next = 0;
    check("frame_done", 32'(frame_done), 32'(m_done_cur));
    check("busy", 32'(busy), 32'(m_busy));
    if (m_hold) check("valid_held", 32'(pixel_valid), 32'd1);
    if (!m_busy) check("valid_idle", 32'(pixel_valid), 32'd0);
    if (pixel_valid) begin
      check("pix_row", 32'(pix_row), 32'(exp_idx / W));
      check("pix_col", 32'(pix_col), 32'(exp_idx % W));
      check("pixel_out", 32'(pixel_out), 32'(rom_f(exp_idx / W, exp_idx % W)));
    end
  endtask

  // Drive the inputs sampled at the coming rising edge and advance the model.
  task automatic drive(input bit rdy, input bit st, input bit ab);
    bit busy_before;
    pixel_ready = rdy;
    start       = st;
    abort       = ab;
    busy_before = m_busy;
    if (ab) begin
      m_busy = 0; exp_idx = 0; m_hold = 0; m_done_next = 0;
    end else begin
      m_hold = pixel_valid && !rdy;
      if (pixel_valid && rdy) begin
        exp_idx++;
        if (exp_idx == NPIX) begin
          exp_idx     = 0;
          m_done_next = 1;
`ifndef CONTINUOUS_SCAN_EN
          m_busy      = 0;
`endif
        end
      end
      if (st && !busy_before && !m_done_cur) m_busy = 1;
    end
  endtask

  task automatic run_until_head(input int r, input int c, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      observe();
      if (pixel_valid && int'(pix_row) == r && int'(pix_col) == c) begin
        ok = 1;
        break;
      end
      drive(1, 0, 0);
    end
    check("reach_head", 32'(ok), 32'd1);
  endtask

  task automatic finish_frame();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      observe();
      drive(1, 0, 0);
      if (frame_done) begin seen = 1; break; end
    end
    check("frame_end_seen", 32'(seen), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      observe();
      drive(1, 0, 0);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rom_row"}, 32'(rom_pix_row), 32'd0);
    check({pfx, "_rom_col"}, 32'(rom_pix_col), 32'd0);
    check({pfx, "_pixel_out"}, 32'(pixel_out), 32'd0);
    check({pfx, "_pix_row"}, 32'(pix_row), 32'd0);
    check({pfx, "_pix_col"}, 32'(pix_col), 32'd0);
    check({pfx, "_valid"}, 32'(pixel_valid), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(frame_done), 32'd0);
  endtask

`ifndef CONTINUOUS_SCAN_EN
  // One frame with ready held high; optional start pulses at ticks sa/sb.
  task automatic run_full(input int sa, input int sb,
                          output int lat, output int nvalid, output int last_v,
                          output int done_rel, output int ndone);
    int c0;
    observe();
    drive(1, 1, 0);
    c0 = cyc;
    lat = -1; nvalid = 0; last_v = -1; done_rel = -1; ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      observe();
      if (pixel_valid) begin
        if (lat < 0) lat = cyc - c0;
        last_v = cyc - c0;
        nvalid++;
      end
      if (frame_done) begin
        if (done_rel < 0) done_rel = cyc - c0;
        ndone++;
      end
      drive(1, (i == sa) || (i == sb), 0);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [16:0] ra;
    int lat, nvalid, last_v, done_rel, ndone, c0;

    Reset_n = 1'b1; start = 1'b0; abort = 1'b0; pixel_ready = 1'b0;
    #3 Reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1 Reset_n = 1'b1;
    idle_cycles(2);

`ifndef CONTINUOUS_SCAN_EN
    // Full frame, ready high: latency, throughput, frame_done timing.
    run_full(-1, -1, lat, nvalid, last_v, done_rel, ndone);
    check("first_latency", 32'(lat), 32'd3);
    check("valid_count", 32'(nvalid), 32'(NPIX));
    check("last_valid_cycle", 32'(last_v), 32'(NPIX + 2));
    check("done_cycle", 32'(done_rel), 32'(NPIX + 3));
    check("done_count", 32'(ndone), 32'd1);

    // start pulses while busy are ignored.
    run_full(4, 9, lat, nvalid, last_v, done_rel, ndone);
    check("busy_start_valid_count", 32'(nvalid), 32'(NPIX));
    check("busy_start_done_count", 32'(ndone), 32'd1);
`else
    // Continuous scan: wraps to (0,0) and pulses frame_done each frame.
    observe();
    drive(1, 1, 0);
    c0 = cyc;
    ndone = 0;
    for (int i = 1; i <= 39; i++) begin
      observe();
      if (cyc - c0 == NPIX + 3) begin
        check("pix13_valid", 32'(pixel_valid), 32'd1);
        check("pix13_row", 32'(pix_row), 32'd0);
        check("pix13_col", 32'(pix_col), 32'd0);
      end
      if (frame_done) begin
        ndone++;
        check("cont_done_cycle", 32'(cyc - c0), 32'(3 + NPIX * ndone));
      end
      drive(1, 0, 0);
    end
    check("cont_done_count", 32'(ndone), 32'd3);
    check("cont_busy", 32'(busy), 32'd1);
    observe();
    drive(1, 0, 1);
    idle_cycles(2);
`endif

    // Backpressure at (1,2): data held, ROM address frozen.
    observe();
    drive(1, 1, 0);
    run_until_head(1, 2, ok);
    drive(0, 0, 0);
    ra = {rom_pix_row, rom_pix_col};
    for (int i = 0; i < 4; i++) begin
      observe();
      check("stall_rom_addr", 32'({rom_pix_row, rom_pix_col}), 32'(ra));
      drive(0, 0, 0);
    end
`ifndef CONTINUOUS_SCAN_EN
    finish_frame();
`else
    observe();
    drive(1, 0, 1);
`endif
    idle_cycles(2);

    // Abort at (1,1) with the buffer full, then restart from (0,0).
    observe();
    drive(1, 1, 0);
    run_until_head(1, 1, ok);
    drive(0, 0, 0);
    observe();
    drive(0, 1, 1);
    observe();
    check("abort_valid", 32'(pixel_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    drive(1, 0, 0);
    idle_cycles(2);
    observe();
    drive(1, 1, 0);
    run_until_head(0, 0, ok);
    drive(1, 0, 0);
`ifndef CONTINUOUS_SCAN_EN
    finish_frame();
`else
    observe();
    drive(1, 0, 1);
`endif
    idle_cycles(2);

    // Asynchronous reset mid-frame.
    observe();
    drive(1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      observe();
      drive(1, 0, 0);
    end
    #2 Reset_n = 1'b0;
    #1 check_all_zero("midrst");
    start = 1'b0; abort = 1'b0;
    m_busy = 0; exp_idx = 0; m_hold = 0; m_done_next = 0;
    @(posedge Clock);
    @(negedge Clock);
    #1 Reset_n = 1'b1;
    idle_cycles(2);
    observe();
    drive(1, 1, 0);
    run_until_head(0, 0, ok);
    drive(1, 0, 0);
    idle_cycles(3);

    // Randomized ready / start / abort traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rdy, st, ab;
      observe();
      rdy = ($urandom_range(0, 99) < 70);
      st  = ($urandom_range(0, 9) == 0);
      ab  = ($urandom_range(0, 149) == 0);
      drive(rdy, st, ab);
    end
`ifndef CONTINUOUS_SCAN_EN
    for (int i = 0; i < 100; i++) begin
      observe();
      drive(1, 0, 0);
      if (!m_busy && !m_done_next && !busy) break;
    end
`else
    observe();
    drive(1, 0, 1);
`endif
    observe();
    check("final_idle_busy", 32'(busy), 32'd0);
    drive(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
